raw2gray_bin: RTL

Parametrised Bayer-raw to grayscale converter with 2x2 binning. It accepts one raw pixel per `pixel_valid` strobe in raster order, tagged with its column and row number. It emits one gray pixel per complete Bayer quad, equal to the truncated mean of R, Gr, Gb and B, so the output image is half resolution in each axis. It sits between the sensor capture block and the downstream grayscale and edge pipeline, and supersedes the full-resolution converter with configurable pixel width and image geometry.

---
 rtl/raw2gray_bin.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/raw2gray_bin.sv
// raw2gray_bin: Bayer raw to grayscale converter with 2x2 binning.
// Each output pixel is the truncated mean of one complete Bayer quad. Even-row
// pixel pairs are summed into a half-width line buffer and later combined with
// the matching odd-row pair.
// Optional feature: define RAW2GRAY_EDGE_EN to register a border flag
// (gray_pixel_edge) with each output pixel; otherwise the flag is tied to 0.
module raw2gray_bin #(
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned MAX_COLS = 1280,
    parameter int unsigned MAX_ROWS = 960
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pixel,
    input  logic              pixel_valid,
    input  logic [15:0]       col_num,
    input  logic [15:0]       row_num,
    output logic [DATA_W-1:0] gray_pixel,
    output logic              gray_pixel_valid,
    output logic              gray_pixel_edge,
    output logic [14:0]       gray_col,
    output logic [14:0]       gray_row
);

    localparam int unsigned Depth     = MAX_COLS / 2;
    localparam int unsigned AddrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [15:0] ColLim    = 16'(MAX_COLS);
    localparam logic [15:0] RowLim    = 16'(MAX_ROWS);
    // Half-row index that no legal row can produce; marks the buffer as empty.
    localparam logic [14:0] NoPairRow = 15'h7FFF;

    // Line buffer: one even-row pair sum per output column.
    logic [DATA_W:0]   line_buf [Depth];
    logic [DATA_W:0]   lb_rdata_q;
    logic [AddrW-1:0]  lb_addr;
    logic              lb_re;
    logic              lb_we;

    // Held even-column pixel awaiting its odd-column partner.
    logic [DATA_W-1:0] held_q;
    logic              held_valid_q;
    logic [15:0]       held_col_q;
    logic [15:0]       held_row_q;
    logic [14:0]       last_pair_row_q;

    logic              accepted;
    logic              held_live;
    logic              pair_ok;
    logic              out_fire;
    logic [DATA_W:0]   pair_sum;
    logic [DATA_W+1:0] quad_sum;

    logic [DATA_W-1:0] gray_pixel_q;
    logic              gray_valid_q;
    logic [14:0]       gray_col_q;
    logic [14:0]       gray_row_q;

    // Decode the incoming pixel: acceptance, pairing and line-buffer access.
    always_comb begin
        accepted  = pixel_valid && (col_num < ColLim) && (row_num < RowLim);
        // A pixel from another row invalidates the held pixel before pairing.
        held_live = held_valid_q && (held_row_q == row_num);
        pair_ok   = held_live && (held_col_q == {col_num[15:1], 1'b0});
        lb_addr   = col_num[AddrW:1];
        lb_re     = accepted && !col_num[0] && row_num[0];
        lb_we     = accepted && col_num[0] && !row_num[0] && pair_ok;
        out_fire  = accepted && col_num[0] && row_num[0] && pair_ok
                    && (last_pair_row_q == row_num[15:1]);
        pair_sum  = {1'b0, held_q} + {1'b0, pixel};
        quad_sum  = {1'b0, lb_rdata_q} + {2'b0, held_q} + {2'b0, pixel};
    end

    // Track the held pixel and the half-row most recently written to the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_q          <= '0;
            held_valid_q    <= 1'b0;
            held_col_q      <= '0;
            held_row_q      <= '0;
            last_pair_row_q <= NoPairRow;
        end else if (accepted) begin
            if (!col_num[0]) begin
                held_q       <= pixel;
                held_valid_q <= 1'b1;
                held_col_q   <= col_num;
                held_row_q   <= row_num;
            end else if (lb_we || out_fire || !held_live) begin
                held_valid_q <= 1'b0;
            end
            if (lb_we) begin
                last_pair_row_q <= row_num[15:1];
            end
        end
    end

    // Line-buffer storage with 1-cycle synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            line_buf[lb_addr] <= pair_sum;
        end
        if (lb_re) begin
            lb_rdata_q <= line_buf[lb_addr];
        end
    end

    // Register the binned output; data holds between single-cycle strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gray_pixel_q <= '0;
            gray_valid_q <= 1'b0;
            gray_col_q   <= '0;
            gray_row_q   <= '0;
        end else begin
            gray_valid_q <= out_fire;
            if (out_fire) begin
                gray_pixel_q <= quad_sum[DATA_W+1:2];
                gray_col_q   <= col_num[15:1];
                gray_row_q   <= row_num[15:1];
            end
        end
    end

    assign gray_pixel       = gray_pixel_q;
    assign gray_pixel_valid = gray_valid_q;
    assign gray_col         = gray_col_q;
    assign gray_row         = gray_row_q;

`ifdef RAW2GRAY_EDGE_EN
    localparam logic [14:0] LastCol = 15'(MAX_COLS / 2 - 1);
    localparam logic [14:0] LastRow = 15'(MAX_ROWS / 2 - 1);

    logic edge_d;
    logic edge_q;

    // Border test on the output coordinates of the quad being completed.
    always_comb begin
        edge_d = (col_num[15:1] == 15'd0) || (col_num[15:1] == LastCol)
                 || (row_num[15:1] == 15'd0) || (row_num[15:1] == LastRow);
    end

    // Edge flag registered alongside gray_pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q <= 1'b0;
        end else if (out_fire) begin
            edge_q <= edge_d;
        end
    end

    assign gray_pixel_edge = edge_q;
`else
    assign gray_pixel_edge = 1'b0;
`endif

endmodule
